// File: rtl/ikari_vreg_pkg.sv
// Shared types for the video-register writer: register addresses, queue entry, issue FSM states.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package ikari_vreg_pkg;

    localparam logic [2:0] ADDR_BSET = 3'd0;
    localparam logic [2:0] ADDR_SSET = 3'd1;
    localparam logic [2:0] ADDR_MSET = 3'd2;
    localparam logic [2:0] ADDR_F1SY = 3'd3;
    localparam logic [2:0] ADDR_F2SY = 3'd4;

    // One queued CPU write: target register select plus its data byte.
    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } vreg_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_STROBE = 2'd2
    } vreg_state_t;

    // Strobe vector ordered {F2SY, F1SY, MSET, SSET, BSET}; unmapped selects give no strobe.
    function automatic logic [4:0] strobe_decode(input logic [2:0] addr);
        logic [4:0] v;
        v = 5'b00000;
        case (addr)
            ADDR_BSET: v = 5'b00001;
            ADDR_SSET: v = 5'b00010;
            ADDR_MSET: v = 5'b00100;
            ADDR_F1SY: v = 5'b01000;
            ADDR_F2SY: v = 5'b10000;
            default:   v = 5'b00000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ikari_vreg_fifo.sv
// Write queue for the video-register writer, DEPTH entries (power of two).
// Latency: an entry pushed on one edge is visible at dout/empty right after that edge.
// Backpressure: push ignored while full, pop ignored while empty; full/empty come from the count register.
module ikari_vreg_fifo
    import ikari_vreg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  vreg_entry_t din,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output vreg_entry_t dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    vreg_entry_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    // Flags are decoded from the registered count so a same-cycle pop never frees a slot early.
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; push+pop together keeps count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ikari_vreg_writer.sv
// Queues CPU register writes and replays them to the video register bank as data-then-strobe; macro VREG_VBLANK_COMMIT_EN gates issue on vblank.
// Latency: data on VD_out one cycle after the push, strobe one cycle later; one write per 3 cycles.
// Backpressure: cpu_busy mirrors queue-full; a mapped write while full is dropped and sets sticky ovf.
module ikari_vreg_writer
    import ikari_vreg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_cen,
    input  logic       cpu_wr,
    input  logic [2:0] cpu_addr,
    input  logic [7:0] cpu_din,
    input  logic       vblank,
    output logic       cpu_busy,
    output logic       ovf,
    output logic [7:0] VD_out,
    output logic       BSET,
    output logic       SSET,
    output logic       MSET,
    output logic       F1SY,
    output logic       F2SY
);

    vreg_state_t  r_state;
    vreg_state_t  w_state_nxt;
    logic [7:0]   r_vd;
    logic [2:0]   r_addr;
    logic [4:0]   r_strobe;
    logic         r_ovf;
    logic         w_wr_req;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_commit_ok;
    vreg_entry_t  w_din;
    vreg_entry_t  w_dout;

    // Only mapped selects (0..4) are queued; the rest vanish silently.
    assign w_wr_req = cpu_cen & cpu_wr & (cpu_addr <= ADDR_F2SY);
    assign w_push   = w_wr_req & ~w_full;
    assign w_din    = '{addr: cpu_addr, data: cpu_din};

`ifdef VREG_VBLANK_COMMIT_EN
    assign w_commit_ok = vblank;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_commit_ok     = 1'b1;
`endif

    ikari_vreg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_dout)
    );

    // Issue FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pop: only IDLE waits on the commit gate, a started transfer always finishes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_commit_ok) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE:  w_state_nxt = ST_STROBE;
            ST_STROBE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Data is latched on pop and held; the strobe register is loaded leaving DRIVE so it is high only in STROBE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vd     <= 8'h00;
            r_addr   <= '0;
            r_strobe <= '0;
        end else begin
            if (w_pop) begin
                r_vd   <= w_dout.data;
                r_addr <= w_dout.addr;
            end
            r_strobe <= (r_state == ST_DRIVE) ? strobe_decode(r_addr) : 5'b00000;
        end
    end

    // Sticky overflow: a mapped write arrived while the queue was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_wr_req && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    // Busy is a pure decode of the registered queue count, no path from the CPU inputs.
    assign cpu_busy = w_full;
    assign ovf      = r_ovf;
    assign VD_out   = r_vd;
    assign BSET     = r_strobe[0];
    assign SSET     = r_strobe[1];
    assign MSET     = r_strobe[2];
    assign F1SY     = r_strobe[3];
    assign F2SY     = r_strobe[4];

endmodule

// File: tb/tb_ikari_vreg_writer.sv
// Directed bench for the video-register writer.
// Inputs driven on the falling edge; outputs sampled on the falling edge and 2ns after the rising edge.
// Strobe events are logged by a monitor and compared against hand-computed sequences.
module tb_ikari_vreg_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_cen;
    logic       cpu_wr;
    logic [2:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       vblank;
    logic       cpu_busy;
    logic       ovf;
    logic [7:0] VD_out;
    logic       BSET, SSET, MSET, F1SY, F2SY;
    logic [4:0] strb;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [4:0] s;
        logic [7:0] d;
        int         c;
    } ev_t;
    ev_t        log_q[$];
    logic [7:0] prev_vd;

    always #5 clk = ~clk;

    ikari_vreg_writer #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_cen  (cpu_cen),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .vblank   (vblank),
        .cpu_busy (cpu_busy),
        .ovf      (ovf),
        .VD_out   (VD_out),
        .BSET     (BSET),
        .SSET     (SSET),
        .MSET     (MSET),
        .F1SY     (F1SY),
        .F2SY     (F2SY)
    );

    assign strb = {F2SY, F1SY, MSET, SSET, BSET};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: one-hot strobes, data present the cycle before, log every event.
    always @(posedge clk) begin
        #2;
        if (!reset && strb != 5'b00000) begin
            check("strobe_onehot", 32'($countones(strb)), 32'd1);
            check("vd_before_strobe", {24'd0, VD_out}, {24'd0, prev_vd});
            log_q.push_back('{s: strb, d: VD_out, c: cyc});
        end
        prev_vd = VD_out;
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_cen  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        cpu_cen = 1'b0;
        cpu_wr  = 1'b0;
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [4:0] e_s;
        reset    = 1'b1;
        cpu_cen  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = 3'd0;
        cpu_din  = 8'h00;
        vblank   = 1'b1;

        // Reset state
        cyc_wait(2);
        check("rst_vd", {24'd0, VD_out}, 32'h00);
        check("rst_strb", {27'd0, strb}, 32'd0);
        check("rst_busy", {31'd0, cpu_busy}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        reset = 1'b0;
        cyc_wait(2);

        // Single write addr 3 / 8'h5A: data at +1, F1SY at +2 only
        log_q.delete();
        wr(3'd3, 8'h5A);
        bus_idle();
        check("t1_vd_p0", {24'd0, VD_out}, 32'h00);
        check("t1_strb_p0", {27'd0, strb}, 32'd0);
        @(negedge clk);
        check("t1_vd_p1", {24'd0, VD_out}, 32'h5A);
        check("t1_strb_p1", {27'd0, strb}, 32'd0);
        @(negedge clk);
        check("t1_strb_p2", {27'd0, strb}, 32'b01000);
        check("t1_vd_p2", {24'd0, VD_out}, 32'h5A);
        @(negedge clk);
        check("t1_strb_p3", {27'd0, strb}, 32'd0);
        check("t1_vd_p3", {24'd0, VD_out}, 32'h5A);
        cyc_wait(2);

        // Back-to-back writes 1..5 to addr 0..4: in order, 3 cycles apart
        log_q.delete();
        for (int i = 0; i < 5; i++) wr(3'(i), 8'(i + 1));
        bus_idle();
        cyc_wait(16);
        check("t2_count", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            e_s = 5'b00001 << i;
            check($sformatf("t2_strb%0d", i), {27'd0, log_q[i].s}, {27'd0, e_s});
            check($sformatf("t2_vd%0d", i), {24'd0, log_q[i].d}, 32'(i + 1));
            if (i > 0) check($sformatf("t2_gap%0d", i), 32'(log_q[i].c - log_q[i-1].c), 32'd3);
        end

        // Unmapped write: no strobe, data unchanged, no overflow
        log_q.delete();
        wr(3'd6, 8'hFF);
        bus_idle();
        cyc_wait(6);
        check("t3_no_strobe", 32'(log_q.size()), 32'd0);
        check("t3_vd_hold", {24'd0, VD_out}, 32'h05);
        check("t3_ovf", {31'd0, ovf}, 32'd0);
        check("t3_busy", {31'd0, cpu_busy}, 32'd0);

`ifdef VREG_VBLANK_COMMIT_EN
        // Stalled by vblank=0: fill, drop, then a push dropped in the same cycle as the first pop
        log_q.delete();
        vblank = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(3'(i), 8'(8'h20 + i));
            if (i == 4) begin
                check("t4_busy_after4", {31'd0, cpu_busy}, 32'd1);
                check("t4_ovf_before5", {31'd0, ovf}, 32'd0);
            end
        end
        @(negedge clk);
        check("t4_ovf_after5", {31'd0, ovf}, 32'd1);
        check("t4_busy_after5", {31'd0, cpu_busy}, 32'd1);
        check("t4_stalled", 32'(log_q.size()), 32'd0);
        vblank   = 1'b1;
        cpu_addr = 3'd0;
        cpu_din  = 8'h2F;
        bus_idle();
        check("t4_busy_after_pop", {31'd0, cpu_busy}, 32'd0);
        check("t4_ovf_sticky", {31'd0, ovf}, 32'd1);
        cyc_wait(20);
        check("t4_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            e_s = 5'b00001 << i;
            check($sformatf("t4_strb%0d", i), {27'd0, log_q[i].s}, {27'd0, e_s});
            check($sformatf("t4_vd%0d", i), {24'd0, log_q[i].d}, 32'(8'h20 + i));
        end
`else
        // Pushes every cycle outrun the 1-per-3 drain: fill after 6, drop 7th and 8th (8th with a pop)
        log_q.delete();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i % 5), 8'(8'h10 + i));
            if (i == 5) check("t4_busy_p4", {31'd0, cpu_busy}, 32'd0);
            if (i == 6) begin
                check("t4_busy_p5", {31'd0, cpu_busy}, 32'd1);
                check("t4_ovf_p5", {31'd0, ovf}, 32'd0);
            end
            if (i == 7) begin
                check("t4_busy_p6", {31'd0, cpu_busy}, 32'd1);
                check("t4_ovf_p6", {31'd0, ovf}, 32'd1);
            end
        end
        bus_idle();
        check("t4_busy_after_pop", {31'd0, cpu_busy}, 32'd0);
        check("t4_ovf_sticky", {31'd0, ovf}, 32'd1);
        cyc_wait(25);
        check("t4_count", 32'(log_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            e_s = 5'b00001 << (i % 5);
            check($sformatf("t4_strb%0d", i), {27'd0, log_q[i].s}, {27'd0, e_s});
            check($sformatf("t4_vd%0d", i), {24'd0, log_q[i].d}, 32'(8'h10 + i));
        end
`endif

        // Reset during DRIVE with another write queued: abort, no strobe, queue flushed
        log_q.delete();
        wr(3'd0, 8'hA1);
        wr(3'd1, 8'hA2);
        bus_idle();
        check("t5_vd_drive", {24'd0, VD_out}, 32'hA1);
        reset = 1'b1;
        #1;
        check("t5_vd_rst", {24'd0, VD_out}, 32'h00);
        check("t5_strb_rst", {27'd0, strb}, 32'd0);
        check("t5_ovf_rst", {31'd0, ovf}, 32'd0);
        cyc_wait(2);
        reset = 1'b0;
        cyc_wait(8);
        check("t5_no_strobe", 32'(log_q.size()), 32'd0);
        check("t5_vd_idle", {24'd0, VD_out}, 32'h00);
        wr(3'd2, 8'h77);
        bus_idle();
        @(negedge clk);
        check("t5_vd_fresh", {24'd0, VD_out}, 32'h77);
        @(negedge clk);
        check("t5_strb_fresh", {27'd0, strb}, 32'b00100);
        cyc_wait(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ikari_vreg_writer.md
IKARI_VREG_WRITER -- requirements
Module: ikari_vreg_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the write-queue depth in entries (power of two, 2..16).
REQ-002 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_cen  in  1  CPU bus-cycle qualifier; sampled only when high.
REQ-005 cpu_wr  in  1  CPU write request; qualified by cpu_cen.
REQ-006 cpu_addr  in  3  register select: 0=BSET, 1=SSET, 2=MSET, 3=F1SY, 4=F2SY, 5..7 unmapped.
REQ-007 cpu_din  in  8  CPU write data.
REQ-008 vblank  in  1  vertical blank; used only with the VREG_VBLANK_COMMIT_EN macro.
REQ-009 cpu_busy  out  1  queue full; CPU SHALL stall while high.
REQ-010 ovf  out  1  sticky flag: a mapped write was dropped.
REQ-011 VD_out  out  8  video data bus driven to the register bank.
REQ-012 BSET, SSET, MSET, F1SY, F2SY  out  1 each  one-cycle write strobes to the register bank.

Function
REQ-013 Push SHALL occur when cpu_cen & cpu_wr & cpu_addr<=4 & !full; the entry holds {addr[2:0], data[7:0]}.
REQ-014 Writes to cpu_addr 5..7 SHALL be discarded without queuing and without setting ovf.
REQ-015 A mapped write presented while full SHALL be dropped and SHALL set ovf.
REQ-016 Full SHALL be evaluated from the registered count before any same-cycle pop, so a pop never frees a slot in the cycle it occurs.
REQ-017 cpu_busy SHALL equal full, registered, with no combinational path from cpu_* inputs.
REQ-018 Issue FSM states SHALL be IDLE, DRIVE and STROBE.
REQ-019 In IDLE with queue non-empty and commit permitted, the FSM SHALL pop the head entry, load VD_out with its data and enter DRIVE.
REQ-020 DRIVE SHALL hold VD_out for exactly 1 cycle, then enter STROBE.
REQ-021 STROBE SHALL assert exactly the one strobe decoded from the entry address for 1 cycle with VD_out unchanged, then enter IDLE.
REQ-022 The data SHALL be on VD_out one cycle before its strobe, matching the bank's one-cycle input register.
REQ-023 At most one strobe SHALL be high in any cycle.
REQ-024 VD_out SHALL hold its last value in IDLE.
REQ-025 Sustained throughput SHALL be one register write per 3 cycles.
REQ-026 Latency from the push cycle on an empty queue SHALL be: VD_out valid at push+1, strobe at push+2.
REQ-027 Writes SHALL issue in arrival order; repeated writes to one address SHALL all issue.
REQ-028 Queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged.

Reset
REQ-030 While reset is high: queue empty, FSM in IDLE, VD_out=8'h00, all strobes=0, cpu_busy=0, ovf=0.
REQ-031 Reset asserted mid-DRIVE or mid-STROBE SHALL abort the transfer immediately with no strobe, and SHALL discard all queued entries.

Configuration
REQ-032 With VREG_VBLANK_COMMIT_EN defined, the FSM SHALL leave IDLE only while vblank=1; a transfer already in DRIVE or STROBE SHALL complete regardless of vblank.
REQ-033 Without VREG_VBLANK_COMMIT_EN, commit SHALL always be permitted and vblank SHALL be ignored.

Structure
REQ-034 Package ikari_vreg_pkg SHALL hold the address constants (ADDR_BSET..ADDR_F2SY), the entry struct typedef and the FSM state enum.
REQ-035 The queue SHALL be a sub-module ikari_vreg_fifo (push, pop, full, empty, dout).

Verification
REQ-036 Write addr 3 data 8'h5A into an empty queue -> VD_out=8'h5A at +1, F1SY pulses at +2 only, other strobes 0.
REQ-037 Back-to-back writes of 8'h01..8'h05 to addr 0..4 -> strobes issue in order BSET, SSET, MSET, F1SY, F2SY, 3 cycles apart, each with its matching VD_out.
REQ-038 With FIFO_DEPTH=4 and the FSM stalled by vblank=0 under VREG_VBLANK_COMMIT_EN, issue 5 writes -> cpu_busy=1 after the 4th, 5th write dropped, ovf=1; raise vblank -> 4 strobes issue.
REQ-039 Write to addr 6 data 8'hFF -> no strobe, VD_out unchanged, ovf=0.
REQ-040 Assert reset in the DRIVE cycle with 2 entries queued -> no strobe ever fires, VD_out=8'h00, queue empty after release.
REQ-041 Push while full with a same-cycle pop -> the push is dropped, ovf=1, count drops by 1.
